digdug_spatram: RTL and testbench
=================================

Name: digdug_spatram

Overview:
- Memory-side responder for the video block's sprite-attribute read port (SPATCL/SPATAD/SPATDT).
- Holds 64 sprites × 2 entries = 128 entries of 24-bit attribute data, as three 8-bit CPU-written banks.
- Returns 24-bit words to the sprite scanline generator.
- On each vertical-blank rising edge, a copy engine snapshots the CPU-side RAM into a display-side shadow RAM, so the video never sees a half-updated sprite table mid-frame.

Parameters:
AW, 7, entry address width (2^AW entries)
DW, 8, data width per bank (three banks concatenated give SPATDT)

Ports:
CLK48M  in  1  system clock, sole clock
RESET_N  in  1  synchronous active-low reset
CPUAD  in  AW  CPU entry address within sprite-attribute window
CPUBK  in  2  CPU bank select: 0 → SPATDT[7:0], 1 → [15:8], 2 → [23:16]; 3 = no bank
CPUWR  in  1  CPU write strobe, one write per CLK48M cycle when high
CPUDI  in  DW  CPU write data
CPUDO  out  DW  CPU read-back data
VBLK  in  1  vertical blank from video; rising edge starts copy
SPATCL  in  1  video read strobe (divided clock, synchronous to CLK48M)
SPATAD  in  AW  video read address
SPATDT  out  3*DW  video read data
COPYBUSY  out  1  copy engine active
COPYDONE  out  1  one-cycle pulse at copy completion

Behaviour:
- Always-on requirements (apply in every case below):
  - Reset values: SPATDT=0, CPUDO=0, COPYBUSY=0, COPYDONE=0, state=IDLE, copy counter=0, VBLK/SPATCL edge registers=0.
  - RAM contents are never cleared by reset; they are preserved.
  - All memories are read-first: a read and a write to the same address in the same cycle return the old data.
- CPU port:
  - CPUWR=1 with CPUBK<3 writes CPUDI to CPU RAM bank CPUBK at CPUAD.
  - CPUBK=3 writes are ignored.
  - CPUDO = CPU RAM[CPUBK][CPUAD], registered, 1-cycle latency. CPUDO=0 when CPUBK=3.
  - CPU access is never stalled, including during a copy.
- Video port:
  - SPATCL rising edge is detected by a single registered compare (same clock domain; no synchronizer).
  - On the edge cycle E, the display RAM is read at SPATAD.
  - SPATDT is updated at E+2 and holds until the next edge.
  - Without an edge, SPATDT holds.
- Copy FSM: IDLE → COPY → DRAIN → IDLE.
  - IDLE: when VBLK=1 and the previous VBLK=0 (cycle T), go to COPY at T+1 with cnt=0.
  - COPY: each cycle reads all three CPU banks at cnt in parallel and increments cnt.
    - The entry read at cnt=n is written into display RAM[n] the following cycle.
    - Leave COPY when cnt=2^AW−1 has been issued (T+128), going to DRAIN.
  - DRAIN (T+129): writes the last entry; the next state is IDLE.
  - COPYBUSY=1 from T+1 through T+129 inclusive. COPYDONE=1 for exactly cycle T+130.
- Boundary cases:
  - VBLK rising edge during COPY/DRAIN: ignored, not queued.
  - A CPU write to entry n before the copy reads n is included in this frame's snapshot. A write after, or in the same cycle, appears next frame.
  - Video reads during a copy return old or new data per entry, depending on write progress. Read-first applies on collision.
  - RESET_N low mid-copy: FSM to IDLE next cycle, COPYBUSY=0, no COPYDONE pulse. Entries already written keep their new values.
  - cnt is AW bits and never wraps during a copy; the terminal compare ends COPY.

Optional Feature:
DIGDUG_SPSHADOW_EN
- Defined: shadow display RAM and copy FSM present, as described above.
- Undefined:
  - No shadow RAM and no FSM. COPYBUSY and COPYDONE are tied to 0.
  - The video read comes directly from the CPU RAM second read port: same E+2 latency, read-first on CPU write collision.
  - VBLK is unused.

Test Plan:
- Reset defaults: hold RESET_N=0 for 4 cycles → SPATDT=0, CPUDO=0, COPYBUSY=0, COPYDONE=0; then CPU writes to bank 0 addr 5 = 0x3C, CPUBK=0 read → CPUDO=0x3C one cycle later.
- Basic copy: write entry 0x12 banks 0/1/2 = 0xA1/0xB2/0xC3, pulse VBLK at T → COPYBUSY high T+1..T+129, COPYDONE at T+130; then SPATCL edge with SPATAD=0x12 → SPATDT=0xC3B2A1 two cycles later.
- Snapshot isolation: after copy, CPU writes entry 0x12 bank 0 = 0xFF with no VBLK → video read still 0xC3B2A1; next VBLK copy → 0xC3B2FF.
- Mid-copy race: during COPY, write entry 0x7F bank 2 = 0x55 at T+10 → after done, SPATDT for 0x7F has [23:16]=0x55. Write entry 0x00 at T+10 → old value until next frame.
- Retrigger and reset: VBLK re-edge at T+50 → COPYDONE only once, at T+130. Separate run: RESET_N=0 at T+60 → COPYBUSY=0 at T+61, no COPYDONE, entries 0..58 updated, entries from 60 upward unchanged.
- Macro off (DIGDUG_SPSHADOW_EN undefined): CPU write entry 3 = 0x11/0x22/0x33, SPATCL edge for addr 3 with no VBLK → SPATDT=0x332211 at E+2, COPYBUSY stays 0.

Source files
------------

// File: rtl/digdug_spatram.sv
// digdug_spatram: sprite-attribute RAM for the video sprite read port.
// Three CPU-written 8-bit banks hold 2^AW entries and form the 24-bit SPATDT word.
// Build option DIGDUG_SPSHADOW_EN: when defined, a display-side shadow RAM is
// refreshed from the CPU RAM on every VBLK rising edge. The video port reads
// only the shadow, so it never sees a half-updated table. When undefined, the
// video port reads the CPU RAM directly and COPYBUSY/COPYDONE stay low.
// RAM contents are not cleared by reset.
module digdug_spatram #(
  parameter int AW = 7,
  parameter int DW = 8
) (
  input  logic            CLK48M,
  input  logic            RESET_N,
  input  logic [AW-1:0]   CPUAD,
  input  logic [1:0]      CPUBK,
  input  logic            CPUWR,
  input  logic [DW-1:0]   CPUDI,
  output logic [DW-1:0]   CPUDO,
  input  logic            VBLK,
  input  logic            SPATCL,
  input  logic [AW-1:0]   SPATAD,
  output logic [3*DW-1:0] SPATDT,
  output logic            COPYBUSY,
  output logic            COPYDONE
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]   r_bank0 [DEPTH];
  logic [DW-1:0]   r_bank1 [DEPTH];
  logic [DW-1:0]   r_bank2 [DEPTH];

  logic [DW-1:0]   r_cpudo;
  logic            r_spatcl;
  logic            r_vid_vld;
  logic [3*DW-1:0] r_vid_rd;
  logic [3*DW-1:0] r_spatdt;
  logic            w_vid_edge;
  logic [3*DW-1:0] w_vid_word;

  assign w_vid_edge = SPATCL & ~r_spatcl;
  assign CPUDO      = r_cpudo;
  assign SPATDT     = r_spatdt;

  // CPU write port; bank 3 selects nothing
  always_ff @(posedge CLK48M) begin
    if (CPUWR) begin
      case (CPUBK)
        2'd0:    r_bank0[CPUAD] <= CPUDI;
        2'd1:    r_bank1[CPUAD] <= CPUDI;
        2'd2:    r_bank2[CPUAD] <= CPUDI;
        default: ;
      endcase
    end
  end

  // CPU read-back with one-cycle latency; read-first against a same-cycle write
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      r_cpudo <= {DW{1'b0}};
    end else begin
      case (CPUBK)
        2'd0:    r_cpudo <= r_bank0[CPUAD];
        2'd1:    r_cpudo <= r_bank1[CPUAD];
        2'd2:    r_cpudo <= r_bank2[CPUAD];
        default: r_cpudo <= {DW{1'b0}};
      endcase
    end
  end

  // Video strobe edge detect, read on the edge cycle, present two cycles later
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      r_spatcl  <= 1'b0;
      r_vid_vld <= 1'b0;
      r_vid_rd  <= {(3*DW){1'b0}};
      r_spatdt  <= {(3*DW){1'b0}};
    end else begin
      r_spatcl  <= SPATCL;
      r_vid_vld <= w_vid_edge;
      if (w_vid_edge) begin
        r_vid_rd <= w_vid_word;
      end
      if (r_vid_vld) begin
        r_spatdt <= r_vid_rd;
      end
    end
  end

`ifdef DIGDUG_SPSHADOW_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            r_vblk;
  logic            w_vblk_edge;
  logic            w_cnt_last;
  logic            r_busy;
  logic            r_done;
  logic            r_cp_vld;
  logic [AW-1:0]   r_cp_addr;
  logic [3*DW-1:0] r_cp_data;
  logic [3*DW-1:0] r_dsp [DEPTH];

  assign w_vblk_edge = VBLK & ~r_vblk;
  assign w_cnt_last  = (r_cnt == {AW{1'b1}});
  assign w_vid_word  = r_dsp[SPATAD];
  assign COPYBUSY    = r_busy;
  assign COPYDONE    = r_done;

  // Copy FSM next state and entry counter; retriggers while busy are dropped
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_vblk_edge) begin
          w_state_nxt = ST_COPY;
          w_cnt_nxt   = {AW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COPY: begin
        if (w_cnt_last) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DRAIN: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state, counter, VBLK edge register and status flags
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= {AW{1'b0}};
      r_vblk  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vblk  <= VBLK;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (r_state == ST_DRAIN);
    end
  end

  // Copy read stage: all three CPU banks at the counter, one entry per cycle
  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      r_cp_vld  <= 1'b0;
      r_cp_addr <= {AW{1'b0}};
      r_cp_data <= {(3*DW){1'b0}};
    end else begin
      r_cp_vld  <= (r_state == ST_COPY);
      r_cp_addr <= r_cnt;
      r_cp_data <= {r_bank2[r_cnt], r_bank1[r_cnt], r_bank0[r_cnt]};
    end
  end

  // Display RAM write stage; a write already in flight completes even under reset
  always_ff @(posedge CLK48M) begin
    if (r_cp_vld) begin
      r_dsp[r_cp_addr] <= r_cp_data;
    end
  end
`else
  logic w_unused_vblk;

  assign w_unused_vblk = VBLK;
  assign w_vid_word    = {r_bank2[SPATAD], r_bank1[SPATAD], r_bank0[SPATAD]};
  assign COPYBUSY      = 1'b0;
  assign COPYDONE      = 1'b0;
`endif

endmodule

// File: tb/tb_digdug_spatram.sv
// Self-checking bench for digdug_spatram: table-driven CPU port vectors plus
// hand-written video-read and copy-engine sequences.
module tb_digdug_spatram;
  logic        CLK48M = 1'b0;
  logic        RESET_N;
  logic [6:0]  CPUAD;
  logic [1:0]  CPUBK;
  logic        CPUWR;
  logic [7:0]  CPUDI;
  logic [7:0]  CPUDO;
  logic        VBLK;
  logic        SPATCL;
  logic [6:0]  SPATAD;
  logic [23:0] SPATDT;
  logic        COPYBUSY;
  logic        COPYDONE;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  cpu_m [3][128];
  logic [23:0] dsp_m [128];
  logic [23:0] new_dsp [128];
  logic [23:0] last_spat;

  typedef struct {
    logic       wr;
    logic [1:0] bk;
    logic [6:0] ad;
    logic [7:0] di;
    logic       chk;
    logic [7:0] exp;
  } cpu_vec_t;

  cpu_vec_t tbl [17];

  digdug_spatram #(.AW(7), .DW(8)) dut (
    .CLK48M(CLK48M), .RESET_N(RESET_N), .CPUAD(CPUAD), .CPUBK(CPUBK),
    .CPUWR(CPUWR), .CPUDI(CPUDI), .CPUDO(CPUDO), .VBLK(VBLK),
    .SPATCL(SPATCL), .SPATAD(SPATAD), .SPATDT(SPATDT),
    .COPYBUSY(COPYBUSY), .COPYDONE(COPYDONE)
  );

  always #5 CLK48M = ~CLK48M;

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int b, input int a);
    return 8'((a * 7) + (b * 85) + 3);
  endfunction

  function automatic logic [23:0] vexp(input int a);
`ifdef DIGDUG_SPSHADOW_EN
    return dsp_m[a];
`else
    return {cpu_m[2][a], cpu_m[1][a], cpu_m[0][a]};
`endif
  endfunction

  task automatic cpu_wr(input int bk, input int a, input logic [7:0] d);
    CPUWR = 1'b1; CPUBK = 2'(bk); CPUAD = 7'(a); CPUDI = d;
    tick();
    CPUWR = 1'b0;
    cpu_m[bk][a] = d;
  endtask

  // Edge on SPATCL at cycle E: SPATDT keeps its old value at E+1, new at E+2
  task automatic vid_read(input int a, input logic [23:0] exp, input string nm);
    SPATAD = 7'(a); SPATCL = 1'b1;
    tick();
    check({nm, "_e1"}, SPATDT, last_spat);
    SPATCL = 1'b0;
    tick();
    check({nm, "_e2"}, SPATDT, exp);
    last_spat = exp;
  endtask

`ifdef DIGDUG_SPSHADOW_EN
  // CPU write during a copy at cycle T+c; it is in the snapshot only if c <= entry
  task automatic race_wr(input int c, input int bk, input int a, input logic [7:0] d);
    CPUWR = 1'b1; CPUBK = 2'(bk); CPUAD = 7'(a); CPUDI = d;
    cpu_m[bk][a] = d;
    if (c <= a) new_dsp[a][8*bk +: 8] = d;
  endtask

  task automatic run_copy(input int rst_at, input bit race, input string nm);
    int busy_n, done_n, done_at, first_busy;
    busy_n = 0; done_n = 0; done_at = 0; first_busy = 0;
    for (int e = 0; e < 128; e++) new_dsp[e] = {cpu_m[2][e], cpu_m[1][e], cpu_m[0][e]};
    VBLK = 1'b1;
    for (int c = 1; c <= 135; c++) begin
      tick();
      if (COPYBUSY === 1'b1) busy_n++;
      if (c == 1) first_busy = int'(COPYBUSY);
      if (COPYDONE === 1'b1) begin done_n++; done_at = c; end
      CPUWR = 1'b0;
      VBLK = (race && c == 50) ? 1'b1 : 1'b0;
      RESET_N = (c == rst_at) ? 1'b0 : 1'b1;
      if (race) begin
        if (c == 10) race_wr(c, 2, 127, 8'h55);
        if (c == 11) race_wr(c, 0, 0, 8'h0A);
        if (c == 20) race_wr(c, 0, 19, 8'h5E);
        if (c == 21) race_wr(c, 0, 21, 8'h6F);
      end
    end
    if (rst_at == 0) begin
      check({nm, "_busy_first"}, first_busy, 1);
      check({nm, "_busy_cycles"}, busy_n, 129);
      check({nm, "_done_count"}, done_n, 1);
      check({nm, "_done_at"}, done_at, 130);
      for (int e = 0; e < 128; e++) dsp_m[e] = new_dsp[e];
    end else begin
      check({nm, "_busy_cycles"}, busy_n, rst_at);
      check({nm, "_done_count"}, done_n, 0);
      for (int e = 0; e <= rst_at - 2; e++) dsp_m[e] = new_dsp[e];
      last_spat = 24'h0;
    end
  endtask
`endif

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 7'h05, 8'h3C, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 2'd0, 7'h05, 8'h00, 1'b1, 8'h3C};
    tbl[2]  = '{1'b1, 2'd1, 7'h05, 8'h5A, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 2'd1, 7'h05, 8'h00, 1'b1, 8'h5A};
    tbl[4]  = '{1'b0, 2'd0, 7'h05, 8'h00, 1'b1, 8'h3C};
    tbl[5]  = '{1'b1, 2'd3, 7'h05, 8'hFF, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 2'd0, 7'h05, 8'h00, 1'b1, 8'h3C};
    tbl[7]  = '{1'b0, 2'd1, 7'h05, 8'h00, 1'b1, 8'h5A};
    tbl[8]  = '{1'b1, 2'd0, 7'h05, 8'h77, 1'b1, 8'h3C};
    tbl[9]  = '{1'b0, 2'd0, 7'h05, 8'h00, 1'b1, 8'h77};
    tbl[10] = '{1'b1, 2'd2, 7'h7F, 8'h99, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 2'd2, 7'h00, 8'h44, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 2'd2, 7'h7F, 8'h00, 1'b1, 8'h99};
    tbl[13] = '{1'b0, 2'd2, 7'h00, 8'h00, 1'b1, 8'h44};
    tbl[14] = '{1'b0, 2'd3, 7'h00, 8'h00, 1'b1, 8'h00};
    tbl[15] = '{1'b0, 2'd0, 7'h05, 8'hAB, 1'b1, 8'h77};
    tbl[16] = '{1'b0, 2'd0, 7'h05, 8'h00, 1'b1, 8'h77};

    RESET_N = 1'b0; CPUAD = 7'h0; CPUBK = 2'd0; CPUWR = 1'b0; CPUDI = 8'h0;
    VBLK = 1'b0; SPATCL = 1'b0; SPATAD = 7'h0; last_spat = 24'h0;
    repeat (4) tick();
    check("rst_spatdt", SPATDT, 24'h0);
    check("rst_cpudo", CPUDO, 8'h0);
    check("rst_busy", COPYBUSY, 1'b0);
    check("rst_done", COPYDONE, 1'b0);
    RESET_N = 1'b1;

    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 128; a++) cpu_wr(b, a, pat(b, a));

    for (int i = 0; i < 17; i++) begin
      CPUWR = tbl[i].wr; CPUBK = tbl[i].bk; CPUAD = tbl[i].ad; CPUDI = tbl[i].di;
      tick();
      CPUWR = 1'b0;
      if (tbl[i].wr && tbl[i].bk != 2'd3) cpu_m[tbl[i].bk][tbl[i].ad] = tbl[i].di;
      if (tbl[i].chk) check($sformatf("cpu_vec%0d", i), CPUDO, tbl[i].exp);
    end

`ifdef DIGDUG_SPSHADOW_EN
    cpu_wr(0, 8'h12, 8'hA1); cpu_wr(1, 8'h12, 8'hB2); cpu_wr(2, 8'h12, 8'hC3);
    run_copy(0, 1'b0, "basic");
    vid_read(8'h12, 24'hC3B2A1, "basic_12");
    vid_read(8'h7F, vexp(127), "basic_7f");
    vid_read(8'h00, vexp(0), "basic_00");

    cpu_wr(0, 8'h12, 8'hFF);
    vid_read(8'h12, 24'hC3B2A1, "isolate_12");

    run_copy(0, 1'b1, "race");
    vid_read(8'h12, 24'hC3B2FF, "race_12");
    vid_read(8'h7F, vexp(127), "race_7f");
    check("race_7f_b2", SPATDT[23:16], 8'h55);
    vid_read(8'h00, vexp(0), "race_00");
    check("race_00_old", SPATDT[7:0], 8'h03);
    vid_read(19, vexp(19), "race_19");
    check("race_19_old", SPATDT[7:0], 8'h88);
    vid_read(21, vexp(21), "race_21");
    check("race_21_new", SPATDT[7:0], 8'h6F);

    run_copy(0, 1'b0, "refresh");
    vid_read(8'h00, vexp(0), "refresh_00");
    check("refresh_00_new", SPATDT[7:0], 8'h0A);

    cpu_wr(1, 0, 8'hD0); cpu_wr(1, 58, 8'hD1); cpu_wr(1, 60, 8'hD2); cpu_wr(1, 127, 8'hD3);
    run_copy(60, 1'b0, "rstcopy");
    vid_read(0, vexp(0), "rst_00");
    check("rst_00_new", SPATDT[15:8], 8'hD0);
    vid_read(58, vexp(58), "rst_58");
    check("rst_58_new", SPATDT[15:8], 8'hD1);
    vid_read(60, vexp(60), "rst_60");
    check("rst_60_old", SPATDT[15:8], pat(1, 60));
    vid_read(127, vexp(127), "rst_7f");
    check("rst_7f_old", SPATDT[15:8], pat(1, 127));
`else
    cpu_wr(0, 3, 8'h11); cpu_wr(1, 3, 8'h22); cpu_wr(2, 3, 8'h33);
    vid_read(3, 24'h332211, "direct_03");
    vid_read(8'h7F, vexp(127), "direct_7f");
    vid_read(8'h00, vexp(0), "direct_00");

    // Video edge and CPU write to the same entry in the same cycle
    SPATAD = 7'd3; SPATCL = 1'b1;
    CPUWR = 1'b1; CPUBK = 2'd0; CPUAD = 7'd3; CPUDI = 8'hEE;
    tick();
    CPUWR = 1'b0; cpu_m[0][3] = 8'hEE;
    check("coll_e1", SPATDT, last_spat);
    SPATCL = 1'b0;
    tick();
    check("coll_e2", SPATDT, 24'h332211);
    last_spat = 24'h332211;
    vid_read(3, 24'h3322EE, "after_coll");

    // SPATCL held high: no new edge, SPATDT holds
    SPATAD = 7'd3; SPATCL = 1'b1;
    tick();
    SPATAD = 7'h7F;
    repeat (4) tick();
    check("hold_high", SPATDT, 24'h3322EE);
    SPATCL = 1'b0;
    tick();

    begin
      int busy_n, done_n;
      busy_n = 0; done_n = 0;
      VBLK = 1'b1;
      for (int c = 1; c <= 140; c++) begin
        tick();
        VBLK = 1'b0;
        if (COPYBUSY !== 1'b0) busy_n++;
        if (COPYDONE !== 1'b0) done_n++;
      end
      check("off_busy", busy_n, 0);
      check("off_done", done_n, 0);
    end
    vid_read(3, 24'h3322EE, "off_after_vblk");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
